// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK counter bank and its cells.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_UP = 2'b01,
    MODE_DN = 2'b10,
    MODE_LD = 2'b11
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit with enable, synchronous clear and parallel load.
// Load is folded into the JK inputs as j=d, k=~d.
module jk_cell (
  input  logic clk,
  input  logic clr_n,
  input  logic rst_val,
  input  logic en,
  input  logic sclr,
  input  logic load,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic j_eff;
  logic k_eff;
  logic q_next;

  always_comb begin
    j_eff  = load ? d : j;
    k_eff  = load ? ~d : k;
    q_next = q;
    case ({j_eff, k_eff})
      2'b01:   q_next = 1'b0;
      2'b10:   q_next = 1'b1;
      2'b11:   q_next = ~q;
      default: q_next = q;
    endcase
  end

  // qbar is its own register so it stays glitch-free and equal to ~q
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q    <= rst_val;
      qbar <= ~rst_val;
    end else if (en) begin
      if (sclr) begin
        q    <= 1'b0;
        qbar <= 1'b1;
      end else begin
        q    <= q_next;
        qbar <= ~q_next;
      end
    end
  end

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK cells: per-bit JK, up/down toggle counting, parallel load.
// Define JK_COUNTER_SAT_EN for saturating counts instead of modular wrap.
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             sclr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrapped
);

  jk_mode_t         mode_e;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] j_bit;
  logic [WIDTH-1:0] k_bit;
  logic             load;
  logic             at_limit;

  assign mode_e = jk_mode_t'(mode);

  // Toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    logic c;
    logic b;
    c = 1'b1;
    b = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i]  = c;
      borrow[i] = b;
      c = c & q[i];
      b = b & ~q[i];
    end
  end

  always_comb begin
    j_bit    = j;
    k_bit    = k;
    load     = 1'b0;
    at_limit = 1'b0;
    case (mode_e)
      MODE_UP: begin
        j_bit    = carry;
        k_bit    = carry;
        at_limit = &q;
      end
      MODE_DN: begin
        j_bit    = borrow;
        k_bit    = borrow;
        at_limit = ~|q;
      end
      MODE_LD: load = 1'b1;
      default: ;
    endcase
`ifdef JK_COUNTER_SAT_EN
    // Pin the count at its limit instead of wrapping
    if (at_limit) begin
      j_bit = '0;
      k_bit = '0;
    end
`endif
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .clr_n   (clr_n),
      .rst_val (RST_VAL[i]),
      .en      (en),
      .sclr    (sclr),
      .load    (load),
      .d       (d[i]),
      .j       (j_bit[i]),
      .k       (k_bit[i]),
      .q       (q[i]),
      .qbar    (qbar[i])
    );
  end

  // tc pulses on each limit edge; wrapped is sticky until sclr or reset
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (en) begin
        if (sclr) begin
          wrapped <= 1'b0;
        end else if (at_limit) begin
          tc      <= 1'b1;
          wrapped <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_counter_bank.sv
// Scoreboard bench for jk_counter_bank (WIDTH=4, RST_VAL=0); honours JK_COUNTER_SAT_EN.
module tb_jk_counter_bank;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         en;
  logic         sclr;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;
  logic         wrapped;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         tc;
    logic         wr;
  } obs_t;

  obs_t exp_q[$];
  obs_t got_q[$];

  logic [W-1:0] m_q;
  logic         m_tc;
  logic         m_wr;

  int checks = 0;
  int errors = 0;

  jk_counter_bank #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .en      (en),
    .sclr    (sclr),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .d       (d),
    .q       (q),
    .qbar    (qbar),
    .tc      (tc),
    .wrapped (wrapped)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, advance the model, capture outputs after the edge
  task automatic step(input logic e, input logic s, input logic [1:0] md,
                      input logic [W-1:0] jj, input logic [W-1:0] kk, input logic [W-1:0] dd);
    obs_t ex;
    obs_t ob;
    @(negedge clk);
    en = e; sclr = s; mode = md; j = jj; k = kk; d = dd;
    if (!e) begin
      m_tc = 1'b0;
    end else if (s) begin
      m_q = '0; m_tc = 1'b0; m_wr = 1'b0;
    end else begin
      case (md)
        2'b00: begin
          for (int b = 0; b < W; b++) begin
            if (jj[b] && kk[b])       m_q[b] = ~m_q[b];
            else if (jj[b])           m_q[b] = 1'b1;
            else if (kk[b])           m_q[b] = 1'b0;
          end
          m_tc = 1'b0;
        end
        2'b01: begin
          if (m_q == {W{1'b1}}) begin
`ifndef JK_COUNTER_SAT_EN
            m_q = '0;
`endif
            m_tc = 1'b1; m_wr = 1'b1;
          end else begin
            m_q = m_q + W'(1); m_tc = 1'b0;
          end
        end
        2'b10: begin
          if (m_q == '0) begin
`ifndef JK_COUNTER_SAT_EN
            m_q = {W{1'b1}};
`endif
            m_tc = 1'b1; m_wr = 1'b1;
          end else begin
            m_q = m_q - W'(1); m_tc = 1'b0;
          end
        end
        default: begin
          m_q = dd; m_tc = 1'b0;
        end
      endcase
    end
    ex.q = m_q; ex.qb = ~m_q; ex.tc = m_tc; ex.wr = m_wr;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    ob.q = q; ob.qb = qbar; ob.tc = tc; ob.wr = wrapped;
    got_q.push_back(ob);
  endtask

  task automatic test_reset();
    en = 1'b0; sclr = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
    clr_n = 1'b1;
    #3 clr_n = 1'b0;
    #1;
    checks++;
    if ({q, qbar, tc, wrapped} !== {4'b0000, 4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async q=%b qbar=%b tc=%b wr=%b expected 0000 1111 0 0", q, qbar, tc, wrapped);
    end
    m_q = '0; m_tc = 1'b0; m_wr = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, '0, '0, '0);
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({q, qbar, tc, wrapped} !== {4'b0000, 4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midcount q=%b qbar=%b tc=%b wr=%b expected 0000 1111 0 0", q, qbar, tc, wrapped);
    end
    m_q = '0; m_tc = 1'b0; m_wr = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    while (exp_q.size() > 0) begin
      obs_t ex = exp_q.pop_front();
      obs_t ob = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL reset_count q/qb/tc/wr got %b expected %b", ob, ex);
      end
    end
  endtask

  task automatic test_jk();
    step(1'b1, 1'b0, 2'b11, '0, '0, 4'b0101);
    step(1'b1, 1'b0, 2'b00, 4'b0011, 4'b0110, '0);
    step(1'b1, 1'b0, 2'b00, 4'b1111, 4'b1111, '0);
    step(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, '0);
    while (exp_q.size() > 0) begin
      obs_t ex = exp_q.pop_front();
      obs_t ob = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL jk_mode q/qb/tc/wr got %b expected %b", ob, ex);
      end
    end
  endtask

  task automatic test_up_wrap();
    step(1'b1, 1'b0, 2'b11, '0, '0, 4'b1110);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, '0, '0, '0);
    step(1'b1, 1'b0, 2'b11, '0, '0, 4'b0100);
    while (exp_q.size() > 0) begin
      obs_t ex = exp_q.pop_front();
      obs_t ob = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL up_wrap q/qb/tc/wr got %b expected %b", ob, ex);
      end
    end
  endtask

  task automatic test_down_gaps();
    step(1'b1, 1'b0, 2'b11, '0, '0, 4'b0001);
    step(1'b1, 1'b0, 2'b10, '0, '0, '0);
    step(1'b0, 1'b0, 2'b10, '0, '0, '0);
    step(1'b1, 1'b0, 2'b10, '0, '0, '0);
    step(1'b1, 1'b1, 2'b10, '0, '0, '0);
    while (exp_q.size() > 0) begin
      obs_t ex = exp_q.pop_front();
      obs_t ob = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL down_gaps q/qb/tc/wr got %b expected %b", ob, ex);
      end
    end
  endtask

  task automatic test_priority();
    step(1'b1, 1'b0, 2'b11, '0, '0, 4'b0110);
    step(1'b0, 1'b1, 2'b11, 4'b1111, 4'b1111, 4'b1001);
    step(1'b1, 1'b1, 2'b11, '0, '0, 4'b1010);
    while (exp_q.size() > 0) begin
      obs_t ex = exp_q.pop_front();
      obs_t ob = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL priority q/qb/tc/wr got %b expected %b", ob, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 2'b11, '0, '0, 4'b1111);
    step(1'b1, 1'b0, 2'b10, '0, '0, '0);
    step(1'b1, 1'b0, 2'b01, '0, '0, '0);
    step(1'b1, 1'b0, 2'b01, '0, '0, '0);
    step(1'b1, 1'b0, 2'b01, '0, '0, '0);
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
           W'($urandom), W'($urandom), W'($urandom));
    while (exp_q.size() > 0) begin
      obs_t ex = exp_q.pop_front();
      obs_t ob = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL back_to_back q/qb/tc/wr got %b expected %b", ob, ex);
      end
    end
  endtask

`ifdef JK_COUNTER_SAT_EN
  task automatic test_saturate();
    step(1'b1, 1'b0, 2'b11, '0, '0, 4'b1111);
    step(1'b1, 1'b0, 2'b01, '0, '0, '0);
    step(1'b1, 1'b0, 2'b01, '0, '0, '0);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0);
    while (exp_q.size() > 0) begin
      obs_t ex = exp_q.pop_front();
      obs_t ob = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL saturate q/qb/tc/wr got %b expected %b", ob, ex);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_jk();
    test_up_wrap();
    test_down_gaps();
    test_priority();
`ifdef JK_COUNTER_SAT_EN
    test_saturate();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_counter_bank.md
Name: jk_counter_bank

Overview:
- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit bank of JK cells sharing one clock.
- Four modes: per-bit JK, synchronous up-count, synchronous down-count, parallel load. Up/down counting uses JK toggle logic (j=k=carry/borrow chain).
- Wrap is reported by a one-cycle terminal-count pulse and a sticky flag.
- Serves as the general register/counter primitive for later counter and sequencer blocks.

Parameters:
- WIDTH, 4, number of JK cells (bits); legal range 2..32.
- RST_VAL, 0, value loaded into q on async reset (WIDTH bits).

Ports:
- clk  input  1  single clock, rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; low = hold all state.
- sclr  input  1  synchronous clear; q <= 0, qualified by en.
- mode  input  2  00 JK, 01 count up, 10 count down, 11 load.
- j  input  WIDTH  per-bit J (mode 00 only).
- k  input  WIDTH  per-bit K (mode 00 only).
- d  input  WIDTH  parallel load data (mode 11 only).
- q  output  WIDTH  register state.
- qbar  output  WIDTH  registered complement; always equals ~q.
- tc  output  1  terminal-count pulse, one cycle.
- wrapped  output  1  sticky wrap/limit flag.

Behaviour:
- Reset (clr_n low, asynchronous, independent of clk):
  - q=RST_VAL, qbar=~RST_VAL, tc=0, wrapped=0.
  - Reset mid-count aborts immediately.
  - First edge after release applies normal rules.
- Priority per rising edge: clr_n > en > sclr > mode.
- en=0:
  - q, qbar and wrapped hold.
  - tc <= 0.
  - sclr is ignored.
- en=1, sclr=1: q <= 0, qbar <= all-ones, tc <= 0, wrapped <= 0; mode ignored.
- Mode 00 (JK), per bit i:
  - j=0,k=0: hold.
  - j=0,k=1: q[i] <= 0.
  - j=1,k=0: q[i] <= 1.
  - j=1,k=1: q[i] <= ~q[i].
  - tc <= 0.
- Mode 01 (up):
  - Bit i toggles when q[i-1:0] is all ones; bit 0 always toggles. Equivalent to q <= q+1 mod 2^WIDTH.
  - Edge from all-ones to 0: tc <= 1, wrapped <= 1. Otherwise tc <= 0.
- Mode 10 (down):
  - Bit i toggles when q[i-1:0] is all zeros. Equivalent to q <= q-1 mod 2^WIDTH.
  - Edge from 0 to all-ones: tc <= 1, wrapped <= 1. Otherwise tc <= 0.
- Mode 11 (load): q <= d, tc <= 0, wrapped unchanged.
- Latency: q, qbar, tc and wrapped all update on the same edge as the triggering command; no combinational input-to-output paths.
- tc high for exactly one cycle per wrap event. Consecutive wraps (e.g. WIDTH=2, continuous count) pulse tc once every 2^WIDTH enabled cycles.
- Mode changes take effect on the next edge with no bubble. Switching up to down at all-ones does not assert tc.

Optional Feature:
- Macro: JK_COUNTER_SAT_EN.
- Defined (saturating count):
  - Up at all-ones holds q; down at 0 holds q.
  - In both cases tc <= 1 and wrapped <= 1 on every such edge (tc stays high while the count is pinned).
  - No wrap ever occurs.
- Undefined: modular wrap as described above. The saturation compare logic is absent.

Decomposition:
- Shared package jk_pkg:
  - Mode encoding constants MODE_JK=2'b00, MODE_UP=2'b01, MODE_DN=2'b10, MODE_LD=2'b11.
  - typedef jk_mode_t.
- Sub-module jk_cell: one bit with clk, clr_n, rst_val, en, sclr, load, d, j, k; outputs q, qbar.
  - The bank generates WIDTH instances.
  - The top level computes the per-bit j/k from mode and the carry/borrow chain; load is presented as j=d, k=~d.

Test Plan (WIDTH=4, RST_VAL=0):
1. Reset behaviour: assert clr_n=0 between clock edges, release; then up-count 3 cycles, assert clr_n=0 mid-cycle → q=0000 and qbar=1111 immediately, not at the next edge; tc=0; wrapped=0.
2. JK mode: q=0101, j=0011, k=0110 → q=0011 after one edge; repeat with j=k=1111 → q=1100.
3. Up wrap: load 1110, mode up 3 edges → q 1111, 0000, 0001; tc high only in the 0000 cycle; wrapped=1 and stays 1.
4. Down wrap with enable gaps: load 0001, mode down, en toggling 1,0,1 → q 0000, 0000, 1111; tc high only after the third edge; sclr=1 with en=1 → q=0000, wrapped=0.
5. Priority: en=0 with sclr=1 → q held; en=1, sclr=1, mode=11, d=1010 → q=0000 (sclr wins).
6. JK_COUNTER_SAT_EN defined: load 1111, mode up 2 edges → q stays 1111, tc=1 both cycles; switch to mode 00 → tc=0.
